tqvp_qam_mapper: RTL

TQVP_QAM_MAPPER -- requirements
Module: tqvp_qam_mapper

---
 rtl/tqvp_qam_pkg.sv | 39 +++
 rtl/tqvp_sym_fifo.sv | 46 ++++
 rtl/tqvp_qam_mapper.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/tqvp_qam_pkg.sv
// tqvp_qam_pkg: mode, state and register encodings plus Gray level tables; 64QAM table only with TQVP_QAM64_EN
package tqvp_qam_pkg;

    typedef enum logic [1:0] {MODE_BPSK, MODE_QPSK, MODE_16QAM, MODE_64QAM} mode_e;

    typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DRAIN} state_e;

    localparam logic [3:0] ADDR_CTRL   = 4'h0;
    localparam logic [3:0] ADDR_STATUS = 4'h1;
    localparam logic [3:0] ADDR_DATA   = 4'h2;
    localparam logic [3:0] ADDR_LEVEL  = 4'h3;
    localparam logic [3:0] ADDR_HEAD_I = 4'h4;
    localparam logic [3:0] ADDR_HEAD_Q = 4'h5;
    localparam logic [3:0] ADDR_CLEAR  = 4'h6;

    function automatic logic [2:0] bps_of(input mode_e m);
        return m == MODE_BPSK ? 3'd1 : m == MODE_QPSK ? 3'd2 : m == MODE_16QAM ? 3'd4 : 3'd6;
    endfunction

    function automatic logic signed [3:0] gray16(input logic [1:0] b);
        return b == 2'b00 ? -4'sd3 : b == 2'b01 ? -4'sd1 : b == 2'b11 ? 4'sd1 : 4'sd3;
    endfunction

`ifdef TQVP_QAM64_EN
    function automatic logic signed [3:0] gray64(input logic [2:0] b);
        case (b)
            3'b000:  return -4'sd7;
            3'b001:  return -4'sd5;
            3'b011:  return -4'sd3;
            3'b010:  return -4'sd1;
            3'b110:  return 4'sd1;
            3'b111:  return 4'sd3;
            3'b101:  return 4'sd5;
            default: return 4'sd7;
        endcase
    endfunction
`endif

endpackage

// File: rtl/tqvp_sym_fifo.sv
// tqvp_sym_fifo: synchronous symbol FIFO, head output forced to zero while empty
module tqvp_sym_fifo #(
    parameter int W     = 12,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [W-1:0]             din,
    input  logic                     pop,
    output logic [W-1:0]             dout,
    output logic                     valid,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   level
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wp, rp;
    logic          do_push, do_pop;

    assign valid   = level != '0;
    assign full    = level == (AW+1)'(DEPTH);
    assign do_pop  = pop && valid;
    assign do_push = push && (!full || do_pop);
    assign dout    = valid ? mem[rp] : '0;

    // pointer and occupancy tracking
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wp    <= '0;
            rp    <= '0;
            level <= '0;
        end else begin
            if (do_push) wp <= wp + AW'(1);
            if (do_pop) rp <= rp + AW'(1);
            level <= level + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end

    // storage write
    always_ff @(posedge clk) begin
        if (do_push) mem[wp] <= din;
    end

endmodule

// File: rtl/tqvp_qam_mapper.sv
// tqvp_qam_mapper: register-driven bit accumulator and Gray QAM mapper feeding a symbol FIFO; TQVP_QAM64_EN enables 64QAM
module tqvp_qam_mapper
    import tqvp_qam_pkg::*;
#(
    parameter int SAMPLE_W   = 6,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [3:0]          address,
    input  logic                data_write,
    input  logic [7:0]          data_in,
    output logic [7:0]          data_out,
    output logic                sym_valid,
    input  logic                sym_ready,
    output logic [SAMPLE_W-1:0] sym_i,
    output logic [SAMPLE_W-1:0] sym_q,
    output logic                irq
);
    logic                          ctrl_en, ctrl_irq_en;
    mode_e                         ctrl_mode, eff_mode;
    state_e                        state;
    logic [15:0]                   acc, acc_sh, acc_nx;
    logic [4:0]                    cnt, cnt_sh, cnt_nx, used;
    logic [2:0]                    bps;
    logic                          overflow, done, busy;
    logic                          fifo_full, can_push, emit;
    logic                          wr_ctrl, flush, wr_data, wr_clr, accept;
    logic signed [3:0]             mi, mq;
    logic [$clog2(FIFO_DEPTH):0]   level;

`ifdef TQVP_QAM64_EN
    assign eff_mode = ctrl_mode;
`else
    assign eff_mode = ctrl_mode == MODE_64QAM ? MODE_16QAM : ctrl_mode;
`endif

    assign wr_ctrl  = data_write && address == ADDR_CTRL;
    assign flush    = wr_ctrl && data_in[3];
    assign wr_data  = data_write && address == ADDR_DATA;
    assign wr_clr   = data_write && address == ADDR_CLEAR;
    assign accept   = wr_data && cnt <= 5'd8;
    assign can_push = !fifo_full || (sym_valid && sym_ready);
    assign busy     = state != ST_IDLE || cnt != 5'd0;
    assign irq      = ctrl_irq_en && (overflow || done);

    // consume bits for an emitted symbol, then append an accepted byte above what remains
    always_comb begin
        bps    = bps_of(eff_mode);
        emit   = can_push && ((state == ST_RUN && cnt >= 5'(bps)) || (state == ST_DRAIN && cnt != 5'd0));
        used   = !emit ? 5'd0 : cnt < 5'(bps) ? cnt : 5'(bps);
        acc_sh = acc >> used;
        cnt_sh = cnt - used;
        acc_nx = accept ? acc_sh | (16'(data_in) << cnt_sh) : acc_sh;
        cnt_nx = cnt_sh + (accept ? 5'd8 : 5'd0);
    end

    // Gray mapping of the low accumulator bits; bits above cnt are always zero, giving the drain padding
    always_comb begin
        mi = acc[0] ? -4'sd1 : 4'sd1;
        mq = 4'sd0;
        case (eff_mode)
            MODE_QPSK: mq = acc[1] ? -4'sd1 : 4'sd1;
            MODE_16QAM: begin
                mi = gray16(acc[3:2]);
                mq = gray16(acc[1:0]);
            end
`ifdef TQVP_QAM64_EN
            MODE_64QAM: begin
                mi = gray64(acc[5:3]);
                mq = gray64(acc[2:0]);
            end
`endif
            default: ;
        endcase
    end

    // control register, accumulator and overflow flag
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ctrl_en     <= 1'b0;
            ctrl_mode   <= MODE_BPSK;
            ctrl_irq_en <= 1'b0;
            acc         <= '0;
            cnt         <= '0;
            overflow    <= 1'b0;
        end else begin
            if (wr_ctrl) begin
                ctrl_en     <= data_in[0];
                ctrl_mode   <= mode_e'(data_in[2:1]);
                ctrl_irq_en <= data_in[4];
            end
            acc      <= acc_nx;
            cnt      <= cnt_nx;
            overflow <= wr_clr ? 1'b0 : overflow || (wr_data && !accept);
        end
    end

    // IDLE/RUN/DRAIN sequencing; flush overrides everything, drain completion latches done
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
            done  <= 1'b0;
        end else begin
            if (wr_clr) done <= 1'b0;
            if (flush) state <= ST_DRAIN;
            else begin
                case (state)
                    ST_IDLE:  if (ctrl_en) state <= ST_RUN;
                    ST_RUN:   if (!ctrl_en) state <= ST_IDLE;
                    ST_DRAIN: if (cnt == 5'd0) begin
                        state <= ST_IDLE;
                        done  <= 1'b1;
                    end
                    default:  state <= ST_IDLE;
                endcase
            end
        end
    end

    // register read mux
    always_comb begin
        data_out = 8'h00;
        case (address)
            ADDR_CTRL:   data_out = {3'b000, ctrl_irq_en, 1'b0, ctrl_mode, ctrl_en};
            ADDR_STATUS: data_out = {3'b000, done, overflow, !sym_valid, fifo_full, busy};
            ADDR_LEVEL:  data_out = 8'(level);
            ADDR_HEAD_I: data_out = 8'($signed(sym_i));
            ADDR_HEAD_Q: data_out = 8'($signed(sym_q));
            default:     ;
        endcase
    end

    tqvp_sym_fifo #(
        .W     (2 * SAMPLE_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (emit),
        .din   ({SAMPLE_W'(mi), SAMPLE_W'(mq)}),
        .pop   (sym_ready),
        .dout  ({sym_i, sym_q}),
        .valid (sym_valid),
        .full  (fifo_full),
        .level (level)
    );

endmodule
